alu_accumulator_ctrl: RTL
=========================

Name: alu_accumulator_ctrl

Overview:
Sequential front-end that sits directly upstream of the 16-bit combinational ALU and also consumes the ALU's outputs. It accepts operation commands over a valid/ready handshake and drives the ALU operands, carry-in and function code. The ALU result is registered into an accumulator that feeds back as operand A, which gives multi-cycle repeated operations. Final accumulator and flags are presented on a valid/ready result port.

Parameters:
WIDTH, 16, datapath width (ALU operand/result width)
CNT_W, 4, width of the repeat-count field

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_load  input  1  1 = load cmd_operand into the accumulator directly; 0 = ALU operation
cmd_func  input  3  ALU function code for the operation
cmd_operand  input  WIDTH  operand B (or load value)
cmd_cin  input  1  ALU carry-in for the operation
cmd_count  input  CNT_W  extra repeats; the operation executes cmd_count+1 times
alu_a  output  WIDTH  ALU operand A, always equal to acc
alu_b  output  WIDTH  ALU operand B, the registered operand
alu_cin  output  1  registered carry-in
alu_func  output  3  registered function code
alu_w  input  WIDTH  ALU result
alu_zero  input  1  ALU zero flag
alu_neg  input  1  ALU negative flag
acc  output  WIDTH  accumulator
flag_z  output  1  registered zero flag
flag_n  output  1  registered negative flag
res_valid  output  1  result available
res_ready  input  1  consumer accepts the result

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high. On rst: state=IDLE, acc=0, flag_z=0, flag_n=0, operand/func/cin/count registers=0, res_valid=0.
- Reset mid-operation: rst overrides everything, including EXEC and RESULT. The in-flight command is discarded and no result is produced.
- States: IDLE, EXEC, RESULT.
- IDLE:
  - cmd_ready=1, res_valid=0.
  - On cmd_valid & cmd_ready, capture cmd_func, cmd_operand, cmd_cin and cmd_count into registers.
  - If cmd_load=1: acc <= cmd_operand, flag_z <= (cmd_operand==0), flag_n <= cmd_operand[WIDTH-1]. Next state is RESULT, so res_valid rises one cycle after acceptance.
  - If cmd_load=0: next state is EXEC with remaining count = cmd_count.
- EXEC:
  - cmd_ready=0.
  - The ALU is combinational within the cycle: alu_a=acc, alu_b/alu_cin/alu_func come from the registers.
  - Each cycle: acc <= alu_w, flag_z <= alu_zero, flag_n <= alu_neg.
  - If remaining==0, go to RESULT; else remaining <= remaining-1 and stay in EXEC.
  - Latency from acceptance to res_valid is cmd_count+2 cycles.
  - Flags always mirror the ALU flags from the last executed cycle; the controller never recomputes them.
- RESULT:
  - res_valid=1, cmd_ready=0. acc and flags are held stable.
  - On res_valid & res_ready, go to IDLE next cycle. Back-to-back acceptance is not possible; there is at least one IDLE cycle between commands.
  - res_ready low holds RESULT indefinitely.
- ALU-facing outputs: alu_* outputs are valid in every state. Their values outside EXEC are don't-care to the ALU but are deterministic (registered values).
- Commands outside IDLE: cmd_valid while cmd_ready=0 is ignored, and the command must be held by the source.
- Count width: cmd_count is at most 2^CNT_W-1 (15), giving 16 executions. The remaining-count counter never wraps because it stops at 0.
- Width rules: all arithmetic is inside the ALU. The controller only registers WIDTH-bit values, with no extension or truncation.

Optional Feature:
Macro EARLY_EXIT_EN.
- Defined: in EXEC, if alu_zero=1 on any executed cycle, that cycle's result is captured and the state goes to RESULT regardless of the remaining count. A remaining-count output is not added; the count register simply stops.
- Not defined: all cmd_count+1 executions always occur; alu_zero affects only flag_z.

Test Plan:
The bench uses an ALU stub: func=0 gives w=a+b+cin, func=1 gives w=a-b. zero and neg are derived from w.
1. Reset: apply rst for 2 cycles mid-EXEC -> acc=0, flag_z=0, flag_n=0, res_valid=0, cmd_ready=1 the cycle after rst drops.
2. Load: cmd_load=1, operand=16'h8000 -> one cycle later acc=16'h8000, flag_n=1, flag_z=0, res_valid=1. Hold res_ready=0 for 5 cycles -> values stable. Then res_ready=1 -> IDLE.
3. Repeat add: load 16'd10, then func=0, operand=16'd3, cin=1, count=3 -> res_valid 5 cycles after acceptance, acc=16'd26, flag_z=0, flag_n=0.
4. Wrap/flags: load 16'hFFFF, then func=0, operand=16'd1, cin=0, count=0 -> acc=16'h0000, flag_z=1, flag_n=0.
5. Early exit: load 16'd6, then func=1, operand=16'd2, count=7 -> with EARLY_EXIT_EN, acc=0 and flag_z=1 after 3 EXEC cycles. Without it, 8 EXEC cycles give acc=16'hFFF6 and flag_n=1.
6. Handshake: cmd_valid held high during EXEC/RESULT -> no second acceptance until IDLE. cmd_ready deasserts in the acceptance cycle +1.

Source files
------------

// File: rtl/alu_accumulator_ctrl.sv
// Command front-end for a combinational 16-bit ALU: accepts a command, runs it
// cmd_count+1 times with the accumulator fed back as operand A, then presents the result.
// Optional build macro: EARLY_EXIT_EN (leave EXEC on the first zero ALU result).
module alu_accumulator_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_func,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic             cmd_cin,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_func,
  input  logic [WIDTH-1:0] alu_w,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic [WIDTH-1:0] acc,
  output logic             flag_z,
  output logic             flag_n,
  output logic             res_valid,
  input  logic             res_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESULT
  } state_t;

  localparam logic [CNT_W-1:0] cnt_one = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       func_q;
  logic             cin_q;
  logic [CNT_W-1:0] remaining;
  logic             accept;
  logic             exec_now;
  logic             early_exit;

`ifdef EARLY_EXIT_EN
  assign early_exit = alu_zero;
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    exec_now  = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (cmd_valid) state_nxt = cmd_load ? S_RESULT : S_EXEC;
      end
      S_EXEC: begin
        exec_now = 1'b1;
        if (remaining == '0 || early_exit) state_nxt = S_RESULT;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      op_b      <= '0;
      func_q    <= 3'd0;
      cin_q     <= 1'b0;
      remaining <= '0;
    end else begin
      if (accept) begin
        op_b      <= cmd_operand;
        func_q    <= cmd_func;
        cin_q     <= cmd_cin;
        remaining <= cmd_count;
        if (cmd_load) begin
          acc    <= cmd_operand;
          flag_z <= (cmd_operand == '0);
          flag_n <= cmd_operand[WIDTH-1];
        end
      end
      // Flags are taken from the ALU as-is; the controller never recomputes them.
      if (exec_now) begin
        acc    <= alu_w;
        flag_z <= alu_zero;
        flag_n <= alu_neg;
        if (remaining != '0) remaining <= remaining - cnt_one;
      end
    end
  end

  assign alu_a    = acc;
  assign alu_b    = op_b;
  assign alu_cin  = cin_q;
  assign alu_func = func_q;

endmodule
